// File: rtl/uart_bram_ctrl.sv
// uart_bram_ctrl: byte-stream command sequencer between a UART rx/tx pair
// and a single-port BRAM. 'W' frames write a block of bytes into the BRAM;
// 'R' frames read a block back out and send it byte by byte over UART.
module uart_bram_ctrl #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  CMD_WRITE      = 8'h57,
    parameter logic [7:0]  CMD_READ       = 8'h52
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_send,
    input  logic                  tx_busy,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [7:0]            bram_wdata,
    input  logic [7:0]            bram_rdata,
    output logic                  busy,
    output logic                  err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_CNT, WR_DATA,
        RD_REQ, RD_LATCH, TX_SEND, TX_ACK, TX_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic                  is_read_q, is_read_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            cnt_q, cnt_d;      // 9 bits so CNT=0 can hold 256
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [TMO_W-1:0]      tmo_next;
    logic                  tmo_hit;
    logic                  rd_phase;

    logic [7:0]            tx_data_d;
    logic                  tx_send_d;
    logic                  bram_en_d;
    logic                  bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_d;
    logic [7:0]            bram_wdata_d;
    logic                  err_d;

    assign busy     = (state_q != IDLE);
    assign tmo_next = tmo_q + 1'b1;
    assign tmo_hit  = (tmo_next == TMO_W'(TIMEOUT_CYCLES));
    assign rd_phase = state_q inside {RD_REQ, RD_LATCH, TX_SEND, TX_ACK, TX_WAIT};

    // Next-state and next-output logic; strobes are registered so every
    // output leaves the block straight from a flop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        is_read_d    = is_read_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        tmo_d        = '0;
        tx_data_d    = tx_data;
        tx_send_d    = 1'b0;
        bram_en_d    = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr;
        bram_wdata_d = bram_wdata;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE) begin
                        is_read_d = 1'b0;
                        state_d   = GET_ADDR;
                    end else if (rx_data == CMD_READ) begin
                        is_read_d = 1'b1;
                        state_d   = GET_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    state_d = GET_CNT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            GET_CNT: begin
                if (rx_valid) begin
                    cnt_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    if (is_read_q) begin
                        // Issue the first read as the FSM enters RD_REQ.
                        bram_en_d   = 1'b1;
                        bram_addr_d = addr_q;
                        state_d     = RD_REQ;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            WR_DATA: begin
                // Stay here while the final write pulse is on the port so the
                // write strobe never appears outside this state.
                if (bram_we && cnt_q == 9'd0) begin
                    state_d = IDLE;
                end else if (rx_valid) begin
                    bram_en_d    = 1'b1;
                    bram_we_d    = 1'b1;
                    bram_addr_d  = addr_q;
                    bram_wdata_d = rx_data;
                    addr_d       = addr_q + 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            RD_REQ: begin
                state_d = RD_LATCH;
            end
            RD_LATCH: begin
                tx_data_d = bram_rdata;
                state_d   = TX_SEND;
            end
            TX_SEND: begin
                // First cycle raises the strobe, the next one leaves with it.
                if (tx_send) begin
                    state_d = TX_ACK;
                end else if (!tx_busy) begin
                    tx_send_d = 1'b1;
                end
            end
            TX_ACK: begin
                if (tx_busy) begin
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == 9'd1) begin
                        state_d = IDLE;
                    end else begin
                        bram_en_d   = 1'b1;
                        bram_addr_d = addr_q + 1'b1;
                        state_d     = RD_REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bytes arriving during a read are dropped; the read carries on.
        if (rx_valid && rd_phase) begin
            err_d = 1'b1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            tx_data    <= '0;
            tx_send    <= 1'b0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            tx_data    <= tx_data_d;
            tx_send    <= tx_send_d;
            bram_en    <= bram_en_d;
            bram_we    <= bram_we_d;
            bram_addr  <= bram_addr_d;
            bram_wdata <= bram_wdata_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_bram_ctrl.sv
// tb_uart_bram_ctrl: directed bench for uart_bram_ctrl with a behavioural
// BRAM and UART transmitter around the design.
module tb_uart_bram_ctrl;

    localparam int AW     = 8;
    localparam int TMO    = 100;
    localparam int TX_LEN = 20;
    localparam int GAP    = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic          tx_busy = 1'b0;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_wdata;
    logic [7:0]    bram_rdata;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_bram_ctrl #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO),
        .CMD_WRITE     (8'h57),
        .CMD_READ      (8'h52)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_busy   (tx_busy),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata),
        .busy      (busy),
        .err       (err)
    );

    // BRAM model: one-cycle read latency, preloaded with i ^ 0x5A.
    logic [7:0] mem [256];
    logic       mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         bram_rdata     <= mem[bram_addr];
        end
    end

    // Transmitter model: busy from the cycle after tx_send for TX_LEN cycles.
    int tx_left = 0;
    always @(posedge clk) begin
        if (tx_left > 0) begin
            tx_left = tx_left - 1;
            if (tx_left == 0) tx_busy <= 1'b0;
        end else if (tx_send) begin
            tx_busy <= 1'b1;
            tx_left = TX_LEN;
        end
    end

    // Event logs sampled mid-cycle.
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  tx_q [$];
    int          err_pulses = 0;
    int          busy_seen  = 0;
    int          viol       = 0;
    always @(negedge clk) begin
        if (bram_en && bram_we)  wr_q.push_back({bram_addr, bram_wdata});
        if (bram_en && !bram_we) rd_q.push_back(bram_addr);
        if (tx_send)             tx_q.push_back(tx_data);
        if (err)                 err_pulses++;
        if (busy)                busy_seen++;
        if ((tx_send && bram_en) || (bram_we && !bram_en) || (tx_send && tx_busy)) viol++;
    end

    // Expected memory image, built only from the bench's own writes.
    logic [7:0] exp_mem [256];

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        checks++;
        if ({tx_send, bram_en, bram_we, err, busy} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b expected 00000", {tx_send, bram_en, bram_we, err, busy});
            errors++;
        end
        checks++;
        if ({tx_data, bram_addr, bram_wdata} !== 24'h0) begin
            $display("FAIL reset_data: got %h expected 000000", {tx_data, bram_addr, bram_wdata});
            errors++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_basic;
        int w0 = wr_q.size();
        int e0 = err_pulses;
        bit ok;
        logic [15:0] exp [3] = '{16'h10AA, 16'h11BB, 16'h12CC};
        send_byte(8'h57);
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL wr_busy_high: got %b expected 1", busy);
            errors++;
        end
        send_byte(8'h10); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin
            $display("FAIL wr_idle: busy never fell");
            errors++;
        end
        checks++;
        if (wr_q.size() - w0 !== 3) begin
            $display("FAIL wr_count: got %0d expected 3", wr_q.size() - w0);
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_q[w0+i] !== exp[i]) begin
                    $display("FAIL wr_entry%0d: got %h expected %h", i, wr_q[w0+i], exp[i]);
                    errors++;
                end
            end
        end
        checks++;
        if (err_pulses - e0 !== 0) begin
            $display("FAIL wr_err: got %0d pulses expected 0", err_pulses - e0);
            errors++;
        end
        exp_mem[8'h10] = 8'hAA; exp_mem[8'h11] = 8'hBB; exp_mem[8'h12] = 8'hCC;
    endtask

    task automatic test_read_basic;
        int t0 = tx_q.size();
        bit ok;
        logic [7:0] exp [3] = '{8'hAA, 8'hBB, 8'hCC};
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h03);
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin
            $display("FAIL rd_idle: busy never fell");
            errors++;
        end
        checks++;
        if (tx_q.size() - t0 !== 3) begin
            $display("FAIL rd_count: got %0d expected 3", tx_q.size() - t0);
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tx_q[t0+i] !== exp[i]) begin
                    $display("FAIL rd_byte%0d: got %h expected %h", i, tx_q[t0+i], exp[i]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_wrap_and_full_read;
        int w0 = wr_q.size();
        int t0, r0, bad_data, bad_addr;
        bit ok;
        logic [15:0] exp [3] = '{16'hFE01, 16'hFF02, 16'h0003};
        send_byte(8'h57); send_byte(8'hFE); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        wait_idle(200, ok);
        checks++;
        if (wr_q.size() - w0 !== 3) begin
            $display("FAIL wrap_count: got %0d expected 3", wr_q.size() - w0);
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_q[w0+i] !== exp[i]) begin
                    $display("FAIL wrap_entry%0d: got %h expected %h", i, wr_q[w0+i], exp[i]);
                    errors++;
                end
            end
        end
        exp_mem[8'hFE] = 8'h01; exp_mem[8'hFF] = 8'h02; exp_mem[8'h00] = 8'h03;

        t0 = tx_q.size();
        r0 = rd_q.size();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        wait_idle(12000, ok);
        checks++;
        if (!ok || tx_q.size() - t0 !== 256 || rd_q.size() - r0 !== 256) begin
            $display("FAIL full_count: got tx %0d rd %0d expected 256 256", tx_q.size() - t0, rd_q.size() - r0);
            errors++;
        end else begin
            bad_data = 0;
            bad_addr = 0;
            for (int i = 0; i < 256; i++) begin
                if (tx_q[t0+i] !== exp_mem[i]) bad_data++;
                if (rd_q[r0+i] !== 8'(i))      bad_addr++;
            end
            checks++;
            if (bad_data != 0) begin
                $display("FAIL full_data: got %0d wrong bytes expected 0", bad_data);
                errors++;
            end
            checks++;
            if (bad_addr != 0) begin
                $display("FAIL full_addr: got %0d out-of-order addresses expected 0", bad_addr);
                errors++;
            end
        end
    endtask

    task automatic test_bad_cmd;
        int e0 = err_pulses;
        int b0 = busy_seen;
        send_byte(8'h41);
        #1;
        checks++;
        if (err_pulses - e0 !== 1) begin
            $display("FAIL bad_cmd_err: got %0d pulses expected 1", err_pulses - e0);
            errors++;
        end
        checks++;
        if (busy_seen - b0 !== 0) begin
            $display("FAIL bad_cmd_busy: got %0d busy cycles expected 0", busy_seen - b0);
            errors++;
        end
    endtask

    task automatic test_timeout;
        int e0 = err_pulses;
        int w0 = wr_q.size();
        int n = 0;
        send_byte(8'h57);
        @(negedge clk);
        rx_data  = 8'h20;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        while (!err && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TMO) begin
            $display("FAIL timeout_cycle: got %0d expected %0d", n, TMO);
            errors++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL timeout_idle: got busy %b expected 0", busy);
            errors++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (err_pulses - e0 !== 1) begin
            $display("FAIL timeout_pulse: got %0d pulses expected 1", err_pulses - e0);
            errors++;
        end
        checks++;
        if (wr_q.size() !== w0) begin
            $display("FAIL timeout_nowrite: got %0d writes expected 0", wr_q.size() - w0);
            errors++;
        end
    endtask

    task automatic test_rx_during_read;
        int e0 = err_pulses;
        int t0 = tx_q.size();
        int w0 = wr_q.size();
        bit ok;
        logic [7:0] exp [3] = '{8'hAA, 8'hBB, 8'hCC};
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h03);
        repeat (30) @(negedge clk);
        send_byte(8'h57);
        wait_idle(1000, ok);
        checks++;
        if (err_pulses - e0 !== 1) begin
            $display("FAIL inject_err: got %0d pulses expected 1", err_pulses - e0);
            errors++;
        end
        checks++;
        if (!ok || tx_q.size() - t0 !== 3 || wr_q.size() !== w0) begin
            $display("FAIL inject_count: got tx %0d wr %0d expected 3 0", tx_q.size() - t0, wr_q.size() - w0);
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tx_q[t0+i] !== exp[i]) begin
                    $display("FAIL inject_byte%0d: got %h expected %h", i, tx_q[t0+i], exp[i]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int t0, w0, b0, n;
        bit ok;
        // Reset while the first byte of a read is on the wire.
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h03);
        n = 0;
        while (!tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_send, bram_en, bram_we, err, busy, tx_data, bram_addr, bram_wdata} !== 29'h0) begin
            $display("FAIL rst_txwait_outs: got %h expected 0",
                     {tx_send, bram_en, bram_we, err, busy, tx_data, bram_addr, bram_wdata});
            errors++;
        end
        t0 = tx_q.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        checks++;
        if (tx_q.size() !== t0) begin
            $display("FAIL rst_txwait_nosend: got %0d sends expected 0", tx_q.size() - t0);
            errors++;
        end

        // Reset in the middle of a write block.
        w0 = wr_q.size();
        send_byte(8'h57); send_byte(8'h30); send_byte(8'h03); send_byte(8'h11);
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_send, bram_en, bram_we, err, busy, bram_addr, bram_wdata} !== 21'h0) begin
            $display("FAIL rst_wr_outs: got %h expected 0",
                     {tx_send, bram_en, bram_we, err, busy, bram_addr, bram_wdata});
            errors++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        b0 = busy_seen;
        repeat (150) @(negedge clk);
        #1;
        checks++;
        if (wr_q.size() - w0 !== 1 || busy_seen !== b0) begin
            $display("FAIL rst_wr_after: got writes %0d busy %0d expected 1 0", wr_q.size() - w0, busy_seen - b0);
            errors++;
        end

        // Normal operation afterwards.
        t0 = tx_q.size();
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h01);
        wait_idle(500, ok);
        checks++;
        if (!ok || tx_q.size() - t0 !== 1) begin
            $display("FAIL recover_count: got %0d expected 1", tx_q.size() - t0);
            errors++;
        end else begin
            checks++;
            if (tx_q[t0] !== 8'hAA) begin
                $display("FAIL recover_byte: got %h expected aa", tx_q[t0]);
                errors++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_wrap_and_full_read();
        test_bad_cmd();
        test_timeout();
        test_rx_during_read();
        test_reset_mid();
        checks++;
        if (viol !== 0) begin
            $display("FAIL strobe_rules: got %0d bad cycles expected 0", viol);
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bram_ctrl.md
Name: uart_bram_ctrl

Overview:
Command sequencer between the UART receiver/transmitter pair and a single-port BRAM. Parses a byte-level command stream from the receiver: 'W' writes a block of bytes into BRAM; 'R' reads a block out and transmits it over UART. It owns the BRAM port and the transmitter's send strobe. It sits between uart rx/tx and the bram instance in the bram top level.

Parameters:
ADDR_WIDTH, 8, BRAM address width (1..8). The address byte is truncated to ADDR_WIDTH LSBs.
TIMEOUT_CYCLES, 1_000_000, idle clock cycles allowed between received bytes mid-command before abort.
CMD_WRITE, 8'h57, write command byte ('W').
CMD_READ, 8'h52, read command byte ('R').

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_data  input  8  received byte from UART receiver
rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
tx_data  output  8  byte to transmit, held stable from the tx_send cycle until tx_busy falls
tx_send  output  1  one-cycle send request to the transmitter
tx_busy  input  1  transmitter busy; rises the cycle after tx_send is sampled and falls when the stop bit ends
bram_en  output  1  BRAM enable
bram_we  output  1  BRAM write enable
bram_addr  output  ADDR_WIDTH  BRAM address
bram_wdata  output  8  BRAM write data
bram_rdata  input  8  BRAM read data, 1-cycle latency after bram_en with bram_we=0
busy  output  1  high whenever state != IDLE
err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async, any state): state=IDLE; tx_send, bram_en, bram_we, err, busy = 0; tx_data, bram_addr, bram_wdata, address/count registers and timeout counter = 0.
- Frame: CMD, ADDR, CNT, then CNT data bytes (write only). CNT=0 means 256 bytes. The internal counter is 9 bits.
- States: IDLE, GET_ADDR, GET_CNT, WR_DATA, RD_REQ, RD_LATCH, TX_SEND, TX_ACK, TX_WAIT.
- IDLE:
  - rx_valid with CMD_WRITE or CMD_READ: latch direction, go to GET_ADDR.
  - Any other byte: err pulse, remain in IDLE.
- GET_ADDR: on rx_valid, addr <= rx_data[ADDR_WIDTH-1:0], go to GET_CNT.
- GET_CNT: on rx_valid, latch count. Write goes to WR_DATA; read goes to RD_REQ.
- WR_DATA:
  - Each rx_valid drives bram_en=bram_we=1, bram_wdata=rx_data, bram_addr=addr for exactly one cycle, registered on the cycle after rx_valid.
  - Then addr++ and count-- after the write.
  - When the last byte is written, return to IDLE.
- RD_REQ: bram_en=1, bram_we=0 for one cycle, then RD_LATCH.
- RD_LATCH: tx_data <= bram_rdata, go to TX_SEND.
- TX_SEND: if tx_busy=0, pulse tx_send one cycle and go to TX_ACK. Otherwise hold in TX_SEND.
- TX_ACK: wait for tx_busy=1, then go to TX_WAIT.
- TX_WAIT: wait for tx_busy=0, then addr++ and count--. If count reaches 0, go to IDLE; otherwise go to RD_REQ.
- Address arithmetic: modulo 2^ADDR_WIDTH. A block crossing the top address wraps to 0 silently.
- Timeout:
  - In GET_ADDR, GET_CNT and WR_DATA, the counter clears on every rx_valid and increments otherwise.
  - Reaching TIMEOUT_CYCLES: err pulse, go to IDLE.
  - Bytes already written stay in BRAM.
- rx_valid while in RD_REQ..TX_WAIT: byte dropped, err pulse, the read continues unaffected.
- rx_valid and a timeout in the same cycle: rx_valid wins and the counter clears.
- bram_we is never high outside WR_DATA. tx_send is never high outside TX_SEND. bram_en and tx_send are never high in the same cycle.
- Throughput: a write imposes no back-pressure. One UART byte spans far more than 2 cycles.

Test Plan:
- rx 57,10,03,AA,BB,CC -> one-cycle writes addr 0x10=AA, 0x11=BB, 0x12=CC; busy falls after the third write; err never pulses.
- Then rx 52,10,03 -> three tx_send pulses with tx_data AA, BB, CC, each sent only after the previous tx_busy fall; ends in IDLE.
- rx 57,FE,03,01,02,03 -> writes at FE, FF, 00 (wrap). rx 52,00,00 -> 256 tx_send pulses, addresses 00..FF in order.
- rx 0x41 in IDLE -> single err pulse, busy stays 0. rx 57,20 then silence for TIMEOUT_CYCLES (bench sets 100) -> err pulse at cycle 100, IDLE.
- During an 'R' transfer, inject rx_valid with 0x57 -> err pulse, byte ignored, read completes with correct data.
- Assert rst mid-TX_WAIT and mid-WR_DATA -> all outputs 0 immediately, no further tx_send. Next command 52,10,01 operates normally.
